// File: rtl/udp_tx_fifo_reader.sv
// udp_tx_fifo_reader: drains fixed-length UDP packets from the TX FIFO into the UDP TX core,
// serving each core word request with a direct FIFO read and flagging protocol errors.
module udp_tx_fifo_reader #(
   parameter int PKT_WORDS  = 256,
   parameter int IFG_CYCLES = 16
) (
   input  logic        rd_clk,
   input  logic        rd_rst,
   input  logic        enable,
   output logic        fifo_rd_en,
   input  logic [31:0] fifo_rd_data,
   input  logic        fifo_rd_empty,
   input  logic        fifo_almost_empty,
   output logic        udp_tx_start,
   output logic [15:0] udp_tx_byte_num,
   input  logic        udp_tx_req,
   output logic [31:0] udp_tx_data,
   input  logic        udp_tx_done,
   output logic [15:0] pkt_cnt,
   output logic        err_underrun,
   output logic        err_overreq,
   output logic        err_short
);
   typedef enum logic [2:0] {IDLE, START, SEND, WAIT_DONE, GAP} state_t;
   state_t      r_state, w_state_nxt;
   logic [8:0]  r_word_cnt;
   logic [15:0] r_gap_cnt, r_pkt_cnt;
   logic        r_rd_sel, r_err_underrun, r_err_overreq, r_err_short;
   logic        w_in_pkt, w_has_room, w_last, w_serve;

   assign w_in_pkt   = (r_state == SEND) || (r_state == WAIT_DONE);
   assign w_has_room = r_word_cnt < 9'(PKT_WORDS);
   assign w_last     = udp_tx_req && (r_word_cnt == 9'(PKT_WORDS - 1));
   assign w_serve    = (r_state == SEND) && udp_tx_req && w_has_room;

   always_comb begin
      w_state_nxt = r_state;
      fifo_rd_en  = 1'b0;
      case (r_state)
         IDLE:      w_state_nxt = (enable && !fifo_almost_empty) ? START : IDLE;
         START:     w_state_nxt = SEND;
         SEND: begin
            fifo_rd_en  = w_serve && !fifo_rd_empty;
            w_state_nxt = udp_tx_done ? GAP : (w_last ? WAIT_DONE : SEND);
         end
         WAIT_DONE: w_state_nxt = udp_tx_done ? GAP : WAIT_DONE;
         GAP:       w_state_nxt = (r_gap_cnt == 16'(IFG_CYCLES - 1)) ? IDLE : GAP;
         default:   w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         r_state        <= IDLE;
         r_word_cnt     <= '0;
         r_gap_cnt      <= '0;
         r_pkt_cnt      <= '0;
         r_rd_sel       <= 1'b0;
         r_err_underrun <= 1'b0;
         r_err_overreq  <= 1'b0;
         r_err_short    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_rd_sel  <= fifo_rd_en;
         r_gap_cnt <= (r_state == GAP) ? r_gap_cnt + 16'd1 : 16'd0;
         if (r_state == START) r_word_cnt <= '0;
         else if (w_serve) r_word_cnt <= r_word_cnt + 9'd1;
         if (w_in_pkt && udp_tx_done) r_pkt_cnt <= r_pkt_cnt + 16'd1;
         if (w_serve && fifo_rd_empty) r_err_underrun <= 1'b1;
         if (w_in_pkt && udp_tx_req && !w_has_room) r_err_overreq <= 1'b1;
         // a done arriving together with the final request is a complete packet
         if ((r_state == SEND) && udp_tx_done && !w_last) r_err_short <= 1'b1;
      end
   end

   assign udp_tx_start    = (r_state == START);
   assign udp_tx_byte_num = 16'(PKT_WORDS * 4);
   assign udp_tx_data     = r_rd_sel ? fifo_rd_data : 32'd0;
   assign pkt_cnt         = r_pkt_cnt;
   assign err_underrun    = r_err_underrun;
   assign err_overreq     = r_err_overreq;
   assign err_short       = r_err_short;
endmodule

// File: tb/tb_udp_tx_fifo_reader.sv
// tb_udp_tx_fifo_reader: FIFO model plus table of packet scenarios; expected words are queued
// when a request is driven and compared when the DUT presents udp_tx_data.
module tb_udp_tx_fifo_reader;
   localparam int PW  = 4;
   localparam int IFG = 3;

   logic        rd_clk = 1'b0, rd_rst = 1'b1, enable = 1'b0;
   logic        fifo_rd_en, fifo_rd_empty, fifo_almost_empty;
   logic [31:0] fifo_rd_data = 32'd0, udp_tx_data;
   logic        udp_tx_start, udp_tx_req = 1'b0, udp_tx_done = 1'b0;
   logic [15:0] udp_tx_byte_num, pkt_cnt;
   logic        err_underrun, err_overreq, err_short;
   logic        force_empty = 1'b0;
   int          total = 0, bad = 0, cyc = 0, n_push = 0, n_pop = 0, done_cyc = 0, nstart;
   logic [31:0] next_word = 32'h11223344;
   logic [31:0] fifo_q[$], mdl_q[$], exp_q[$];

   typedef struct {
      int          push;
      int          nreq;
      int          empty_at;
      logic [15:0] exp_cnt;
      logic [2:0]  exp_err;
   } vec_t;
   vec_t vecs[7];

   udp_tx_fifo_reader #(.PKT_WORDS(PW), .IFG_CYCLES(IFG)) dut (
      .rd_clk(rd_clk), .rd_rst(rd_rst), .enable(enable),
      .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
      .fifo_rd_empty(fifo_rd_empty), .fifo_almost_empty(fifo_almost_empty),
      .udp_tx_start(udp_tx_start), .udp_tx_byte_num(udp_tx_byte_num),
      .udp_tx_req(udp_tx_req), .udp_tx_data(udp_tx_data), .udp_tx_done(udp_tx_done),
      .pkt_cnt(pkt_cnt), .err_underrun(err_underrun), .err_overreq(err_overreq),
      .err_short(err_short)
   );

   always #5 rd_clk = ~rd_clk;

   assign fifo_rd_empty     = force_empty || (n_push == n_pop);
   assign fifo_almost_empty = (n_push - n_pop) < PW;

   always @(posedge rd_clk) begin
      cyc <= cyc + 1;
      if (fifo_rd_en) begin
         fifo_rd_data <= fifo_q.pop_front();
         n_pop        <= n_pop + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_words(input int n);
      for (int i = 0; i < n; i++) begin
         fifo_q.push_back(next_word);
         mdl_q.push_back(next_word);
         next_word = next_word + 32'd1;
         n_push++;
      end
   endtask

   task automatic wait_start();
      int k = 0;
      while (!udp_tx_start && k < 200) begin
         @(negedge rd_clk);
         k++;
      end
      check("start_seen", udp_tx_start, 1);
      check("byte_num", udp_tx_byte_num, PW * 4);
   endtask

   // entered on the negedge where udp_tx_start is visible
   task automatic pkt(input int nreq, input int empty_at);
      @(negedge rd_clk);
      for (int i = 1; i <= nreq; i++) begin
         logic en_exp;
         en_exp      = (i <= PW) && (i != empty_at) && (mdl_q.size() > 0);
         force_empty = (i == empty_at);
         udp_tx_req  = 1'b1;
         #1;
         check("rd_en", fifo_rd_en, en_exp);
         exp_q.push_back(en_exp ? mdl_q.pop_front() : 32'd0);
         @(negedge rd_clk);
         udp_tx_req  = 1'b0;
         force_empty = 1'b0;
         check("tx_data", udp_tx_data, exp_q.pop_front());
      end
      udp_tx_done = 1'b1;
      done_cyc    = cyc;
      @(negedge rd_clk);
      udp_tx_done = 1'b0;
   endtask

   initial begin
      vecs[0] = '{4,  4, 0, 16'd1, 3'b000};
      vecs[1] = '{12, 4, 0, 16'd2, 3'b000};
      vecs[2] = '{0,  4, 0, 16'd3, 3'b000};
      vecs[3] = '{0,  4, 0, 16'd4, 3'b000};
      vecs[4] = '{4,  5, 0, 16'd5, 3'b010};
      vecs[5] = '{4,  2, 0, 16'd6, 3'b011};
      vecs[6] = '{2,  4, 3, 16'd7, 3'b111};

      repeat (3) @(negedge rd_clk);
      check("rst_rd_en", fifo_rd_en, 0);
      check("rst_start", udp_tx_start, 0);
      check("rst_data", udp_tx_data, 0);
      check("rst_pkt_cnt", pkt_cnt, 0);
      check("rst_errs", {err_underrun, err_overreq, err_short}, 0);
      check("rst_byte_num", udp_tx_byte_num, 16);
      rd_rst = 1'b0;
      enable = 1'b1;
      @(negedge rd_clk);

      for (int v = 0; v < 7; v++) begin
         push_words(vecs[v].push);
         if (v == 0) begin
            @(negedge rd_clk);
            check("start_latency", udp_tx_start, 1);
         end
         wait_start();
         if (v > 0) check("ifg", (cyc - done_cyc) >= IFG + 2, 1);
         pkt(vecs[v].nreq, vecs[v].empty_at);
         check("pkt_cnt", pkt_cnt, vecs[v].exp_cnt);
         check("errs", {err_underrun, err_overreq, err_short}, vecs[v].exp_err);
      end

      // enable dropped mid-packet: this packet finishes, the next one is held off
      push_words(4);
      wait_start();
      enable = 1'b0;
      pkt(4, 0);
      check("pkt_cnt_dis", pkt_cnt, 8);
      push_words(4);
      nstart = 0;
      repeat (30) begin
         @(negedge rd_clk);
         if (udp_tx_start) nstart++;
      end
      check("no_start_disabled", nstart, 0);
      check("underrun_sticky", err_underrun, 1);

      // asynchronous reset in the middle of SEND
      enable = 1'b1;
      wait_start();
      @(negedge rd_clk);
      udp_tx_req = 1'b1;
      #1;
      check("rd_en_pre_rst", fifo_rd_en, 1);
      #2;
      rd_rst = 1'b1;
      #1;
      check("rst_async_rd_en", fifo_rd_en, 0);
      check("rst_async_start", udp_tx_start, 0);
      check("rst_async_data", udp_tx_data, 0);
      check("rst_async_cnt", pkt_cnt, 0);
      check("rst_async_errs", {err_underrun, err_overreq, err_short}, 0);
      udp_tx_req = 1'b0;
      nstart = 0;
      repeat (5) begin
         @(negedge rd_clk);
         if (udp_tx_start) nstart++;
      end
      check("no_start_in_rst", nstart, 0);
      rd_rst = 1'b0;
      @(negedge rd_clk);
      check("start_after_rst", udp_tx_start, 1);
      dut.r_pkt_cnt = 16'hFFFF;
      pkt(4, 0);
      check("pkt_cnt_wrap", pkt_cnt, 0);
      check("errs_clean", {err_underrun, err_overreq, err_short}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
